// File: rtl/lsu_rmw.sv
// Load/store unit: RV32I byte/half/word accesses onto a word-only DMEM, sub-word stores via read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W requests complete at once with resp_err, no DMEM access.
module lsu_rmw #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE} state_t;

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_off;
    logic [2:0]       r_f3;
    logic [15:0]      r_wdata;
    logic [31:0]      r_wbuf;
    logic [31:0]      r_rdata;
    logic             r_resp_valid, r_resp_err;

    logic             w_f3_ok, w_mis;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load, w_merged;
    logic             w_unused;

    assign w_unused = ^{req_addr[31:IDX_W+2]};

    // Stores only have B/H/W encodings; loads also allow BU/HU.
    always_comb begin
        w_f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !req_we;
            default:                w_f3_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_mis = w_f3_ok &&
                   (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && w_f3_ok && !w_mis) begin
                    if (!req_we)                        w_next = S_LOAD;
                    else if (req_funct3[1:0] == 2'b10)  w_next = S_WRITE;
                    else                                w_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_read = 1'b1;
                w_next   = S_IDLE;
            end
            S_RMW_RD: begin
                mem_read = 1'b1;
                w_next   = S_WRITE;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_byte = 8'(mem_rdata >> {r_off, 3'b000});
    assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = mem_rdata;
        if (r_f3[1:0] == 2'b00) w_merged[{r_off, 3'b000} +: 8]         = r_wdata[7:0];
        else                    w_merged[{r_off[1], 4'b0000} +: 16]   = r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_off        <= '0;
            r_f3         <= '0;
            r_wdata      <= '0;
            r_wbuf       <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_idx   <= req_addr[IDX_W+1:2];
                    r_off   <= req_addr[1:0];
                    r_f3    <= req_funct3;
                    r_wdata <= req_wdata[15:0];
                    // Word stores write straight from here; sub-word stores overwrite it with the merge.
                    r_wbuf  <= req_wdata;
                    if (!w_f3_ok || w_mis) begin
                        r_resp_valid <= 1'b1;
                        r_rdata      <= '0;
                        r_resp_err   <= w_mis;
                    end
                end
                S_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_rdata      <= w_load;
                    r_resp_err   <= 1'b0;
                end
                S_RMW_RD: r_wbuf <= w_merged;
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_rdata      <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = {{(32-IDX_W){1'b0}}, r_idx};
    assign mem_wdata  = r_wbuf;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;

endmodule
